// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector with reloadable pattern and match counter
// Ports: ck falling-edge clock, rs async active-low reset, en sample enable, in serial bit,
//        overlap match mode, pat_load/pat_in pattern reload, cnt_clr counter clear,
//        y one-sample match flag, fill valid history bits, match_cnt saturating count, pat active pattern
module seq_detect_param #(
    parameter int N = 4,
    parameter logic [N-1:0] PATTERN = 4'b0110,
    parameter int CNT_W = 8
) (
    input  logic                     ck,
    input  logic                     rs,
    input  logic                     en,
    input  logic                     in,
    input  logic                     overlap,
    input  logic                     pat_load,
    input  logic [N-1:0]             pat_in,
    input  logic                     cnt_clr,
    output logic                     y,
    output logic [$clog2(N+1)-1:0]   fill,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [N-1:0]             pat
);
    localparam int FW = $clog2(N+1);
    logic [N-1:0]  hist, hist_next;
    logic [FW-1:0] fill_inc;
    logic          match;
    always_comb begin
        hist_next = {hist[N-2:0], in};
        fill_inc  = (fill == FW'(N)) ? fill : fill + 1'b1;
        // fill gates out stale history so an all-zero pattern cannot hit on reset contents
        match     = en && !pat_load && (fill_inc == FW'(N)) && (hist_next == pat);
    end
    always_ff @(negedge ck or negedge rs) begin
        if (!rs) begin
            hist      <= '0;
            fill      <= '0;
            y         <= 1'b0;
            match_cnt <= '0;
            pat       <= PATTERN;
        end else begin
            if (pat_load) begin
                pat  <= pat_in;
                hist <= '0;
                fill <= '0;
                y    <= 1'b0;
            end else if (en) begin
                hist <= hist_next;
                fill <= (match && !overlap) ? '0 : fill_inc;
                y    <= match;
            end else begin
                y <= 1'b0;
            end
            if (cnt_clr)
                match_cnt <= '0;
            else if (match && !(&match_cnt))
                match_cnt <= match_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench for seq_detect_param
module tb_seq_detect_param;
    localparam int N = 4;
    localparam int FW = $clog2(N+1);
    logic ck = 0, rs = 0, en = 0, in = 0, overlap = 1, pat_load = 0, cnt_clr = 0;
    logic [N-1:0] pat_in = '0;
    logic y;
    logic [FW-1:0] fill;
    logic [1:0] match_cnt;
    logic [N-1:0] pat;
    typedef struct {logic y; int fill; int cnt; logic [3:0] pat;} exp_t;
    exp_t sb[$];
    int total = 0, bad = 0, nstep = 0;
    logic [3:0] m_hist = '0, m_pat = 4'b0110;
    int m_fill = 0, m_cnt = 0;
    logic [31:0] ys;

    seq_detect_param #(.N(N), .PATTERN(4'b0110), .CNT_W(2)) dut (
        .ck(ck), .rs(rs), .en(en), .in(in), .overlap(overlap), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y), .fill(fill), .match_cnt(match_cnt), .pat(pat)
    );

    always #5 ck = ~ck;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step(input logic e, input logic b, input logic pl = 0,
                        input logic [3:0] pin = 0, input logic clr = 0);
        exp_t x;
        logic m;
        @(posedge ck); #1;
        en = e; in = b; pat_load = pl; pat_in = pin; cnt_clr = clr;
        m = 0;
        if (pl) begin
            m_pat = pin; m_hist = '0; m_fill = 0;
        end else if (e) begin
            m_hist = {m_hist[2:0], b};
            m_fill = (m_fill < N) ? m_fill + 1 : N;
            m = (m_fill == N) && (m_hist == m_pat);
            if (m && !overlap) m_fill = 0;
        end
        if (clr) m_cnt = 0;
        else if (m && m_cnt < 3) m_cnt++;
        x.y = m; x.fill = m_fill; x.cnt = m_cnt; x.pat = m_pat;
        sb.push_back(x);
        @(negedge ck); #1;
        x = sb.pop_front();
        nstep++;
        ys = {ys[30:0], y};
        total++; if (y !== x.y) begin bad++; $display("FAIL step%0d y got %b want %b", nstep, y, x.y); end
        total++; if (fill !== FW'(x.fill)) begin bad++; $display("FAIL step%0d fill got %0d want %0d", nstep, fill, x.fill); end
        total++; if (match_cnt !== 2'(x.cnt)) begin bad++; $display("FAIL step%0d match_cnt got %0d want %0d", nstep, match_cnt, x.cnt); end
        total++; if (pat !== x.pat) begin bad++; $display("FAIL step%0d pat got %b want %b", nstep, pat, x.pat); end
    endtask

    task automatic stream(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1, bits[i]);
    endtask

    task automatic test_reset;
        #12;
        total++; if ({y, fill, match_cnt, pat} !== {1'b0, 3'd0, 2'd0, 4'b0110}) begin
            bad++; $display("FAIL reset got y=%b fill=%0d cnt=%0d pat=%b want 0 0 0 0110", y, fill, match_cnt, pat);
        end
        @(posedge ck); #1;
        rs = 1;
    endtask

    task automatic test_overlap;
        overlap = 1;
        step(0, 0, 1, 4'b0110, 1);
        ys = '0;
        stream(32'b0110110, 7);
        total++; if (ys[6:0] !== 7'b0001001) begin bad++; $display("FAIL overlap y-seq got %b want 0001001", ys[6:0]); end
        total++; if (match_cnt !== 2'd2) begin bad++; $display("FAIL overlap cnt got %0d want 2", match_cnt); end
        total++; if (fill !== 3'd4) begin bad++; $display("FAIL overlap fill got %0d want 4", fill); end
    endtask

    task automatic test_non_overlap;
        overlap = 0;
        step(0, 0, 1, 4'b0110, 1);
        ys = '0;
        stream(32'b0110110, 7);
        total++; if (fill !== 3'd3) begin bad++; $display("FAIL nonov fill got %0d want 3", fill); end
        total++; if (match_cnt !== 2'd1) begin bad++; $display("FAIL nonov cnt1 got %0d want 1", match_cnt); end
        stream(32'b0110, 4);
        total++; if (ys[10:0] !== 11'b00010000001) begin bad++; $display("FAIL nonov y-seq got %b want 00010000001", ys[10:0]); end
        total++; if (match_cnt !== 2'd2) begin bad++; $display("FAIL nonov cnt2 got %0d want 2", match_cnt); end
    endtask

    task automatic test_fill_guard;
        overlap = 1;
        step(0, 0, 1, 4'b0000, 1);
        stream(32'b000, 3);
        total++; if ({y, fill} !== {1'b0, 3'd3}) begin bad++; $display("FAIL guard got y=%b fill=%0d want 0 3", y, fill); end
        step(0, 0); step(0, 0);
        total++; if ({y, fill} !== {1'b0, 3'd3}) begin bad++; $display("FAIL enable-hold got y=%b fill=%0d want 0 3", y, fill); end
        step(1, 0);
        total++; if ({y, match_cnt} !== {1'b1, 2'd1}) begin bad++; $display("FAIL guard-match got y=%b cnt=%0d want 1 1", y, match_cnt); end
    endtask

    task automatic test_reload_reset;
        overlap = 1;
        step(0, 0, 1, 4'b0110, 1);
        stream(32'b011, 3);
        @(posedge ck); #2;
        en = 0; pat_load = 0; cnt_clr = 0;
        rs = 0;
        #1;
        total++; if ({y, fill, pat} !== {1'b0, 3'd0, 4'b0110}) begin
            bad++; $display("FAIL midreset got y=%b fill=%0d pat=%b want 0 0 0110", y, fill, pat);
        end
        m_hist = '0; m_fill = 0; m_cnt = 0; m_pat = 4'b0110;
        @(posedge ck); #1;
        rs = 1;
        step(0, 0, 1, 4'b1011);
        ys = '0;
        stream(32'b1011011, 7);
        total++; if (ys[6:0] !== 7'b0001001) begin bad++; $display("FAIL reload y-seq got %b want 0001001", ys[6:0]); end
        total++; if (match_cnt !== 2'd2) begin bad++; $display("FAIL reload cnt got %0d want 2", match_cnt); end
    endtask

    task automatic test_saturate_clear;
        overlap = 0;
        step(0, 0, 1, 4'b0110, 1);
        for (int i = 0; i < 6; i++) stream(32'b0110, 4);
        total++; if (match_cnt !== 2'd3) begin bad++; $display("FAIL saturate cnt got %0d want 3", match_cnt); end
        stream(32'b011, 3);
        step(1, 0, 0, 4'b0000, 1);
        total++; if ({y, match_cnt} !== {1'b1, 2'd0}) begin bad++; $display("FAIL clear-vs-match got y=%b cnt=%0d want 1 0", y, match_cnt); end
    endtask

    initial begin
        ys = '0;
        test_reset;
        test_overlap;
        test_non_overlap;
        test_fill_guard;
        test_reload_reset;
        test_saturate_clear;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
